// File: rtl/cp0_reg.sv
// cp0_reg: system coprocessor 0 register file for the OpenMIPS pipeline.
// Serves the execute stage's MFC0 read port and commits MTC0 writes from
// writeback. It also holds the Count/Compare timer, samples the external
// interrupt lines into Cause, and exports the architectural registers.
//
// Build option: define CP0_TIMER_EN to implement Count, Compare and the timer
// interrupt. When it is undefined, registers 9 and 11 read as zero, writes to
// them are dropped, and timer_int_o is tied low.
module cp0_reg #(
    parameter logic [31:0] PRID_VALUE   = 32'h004C0102,
    parameter logic [31:0] CONFIG_VALUE = 32'h00008000,
    parameter logic [31:0] STATUS_RST   = 32'h10000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] data_i,
    input  logic [4:0]  raddr_i,
    input  logic [5:0]  int_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] config_o,
    output logic [31:0] prid_o,
    output logic        timer_int_o
);

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;
    localparam logic [4:0] REG_CONFIG  = 5'd16;

    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;

    // Status, Cause and EPC; Cause IP[15:10] tracks the interrupt pins every cycle
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register reading its
        // pre-edge value, so the ordering of statements here cannot matter.
        if (rst) begin
            status <= STATUS_RST;
            cause  <= '0;
            epc    <= '0;
        end else begin
            cause[15:10] <= int_i;
            if (we_i) begin
                case (waddr_i)
                    REG_STATUS: status <= data_i;
                    REG_CAUSE: begin
                        // Only IV, WP and the two software IP bits are writable
                        cause[23:22] <= data_i[23:22];
                        cause[9:8]   <= data_i[9:8];
                    end
                    REG_EPC:    epc <= data_i;
                    default:    ;
                endcase
            end
        end
    end

`ifdef CP0_TIMER_EN
    logic [31:0] count;
    logic [31:0] compare;
    logic        timer_int;

    // Free-running Count, Compare, and the sticky timer request
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            compare   <= '0;
            timer_int <= 1'b0;
        end else begin
            count <= count + 32'd1;
            // The match uses the registered count, so a Count write on the
            // same edge cannot hide a match that was already present.
            if (compare != 32'd0 && count == compare) begin
                timer_int <= 1'b1;
            end
            if (we_i && waddr_i == REG_COUNT) begin
                count <= data_i;
            end
            // A Compare write acknowledges the timer and beats a same-edge match
            if (we_i && waddr_i == REG_COMPARE) begin
                compare   <= data_i;
                timer_int <= 1'b0;
            end
        end
    end

    assign count_o     = count;
    assign compare_o   = compare;
    assign timer_int_o = timer_int;
`else
    assign count_o     = '0;
    assign compare_o   = '0;
    assign timer_int_o = 1'b0;
`endif

    assign status_o = status;
    assign cause_o  = cause;
    assign epc_o    = epc;
    assign config_o = CONFIG_VALUE;
    assign prid_o   = PRID_VALUE;

    // Read mux with no write bypass; the execute stage forwards from mem/wb itself
    always_comb begin
        // NOTE: the default assignment first means every path drives data_o,
        // so no latch is inferred for unlisted register numbers.
        data_o = '0;
        case (raddr_i)
            REG_COUNT:   data_o = count_o;
            REG_COMPARE: data_o = compare_o;
            REG_STATUS:  data_o = status;
            REG_CAUSE:   data_o = cause;
            REG_EPC:     data_o = epc;
            REG_PRID:    data_o = PRID_VALUE;
            REG_CONFIG:  data_o = CONFIG_VALUE;
            default:     data_o = '0;
        endcase
    end

endmodule
